// File: rtl/spi_pwm_multichannel_if.sv
// SPI mode-0 pin bundle for spi_pwm_multichannel.
// The master side drives the clock, select and data in; the slave side returns CIPO.
`timescale 1ns/1ps
interface spi_pwm_multichannel_if;
  logic SCLK;
  logic nCS;
  logic COPI;
  logic CIPO;

  modport master (output SCLK, output nCS, output COPI, input CIPO);
  modport slave  (input SCLK, input nCS, input COPI, output CIPO);
endinterface

// File: rtl/spi_pwm_multichannel.sv
// NUM_CH-channel PWM controller configured over a synchronised SPI mode-0 slave.
// Optional register readback on CIPO is built when SPI_READBACK_EN is defined.
`timescale 1ns/1ps
module spi_pwm_multichannel #(
  parameter int NUM_CH  = 16,
  parameter int CLK_DIV = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_pwm_multichannel_if.slave spi,
  output logic [NUM_CH-1:0]     pwm_out
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ncs_s1, ncs_s2, ncs_d;
  logic copi_s1, copi_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      ncs_s1  <= 1'b0;
      ncs_s2  <= 1'b0;
      ncs_d   <= 1'b0;
      copi_s1 <= 1'b0;
      copi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= spi.SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      ncs_s1  <= spi.nCS;
      ncs_s2  <= ncs_s1;
      ncs_d   <= ncs_s2;
      copi_s1 <= spi.COPI;
      copi_s2 <= copi_s1;
    end
  end

  logic sclk_rise, ncs_rise, ncs_fall;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign ncs_rise  = ncs_s2 & ~ncs_d;
  assign ncs_fall  = ~ncs_s2 & ncs_d;

  // armed is set only by a real nCS falling edge, so bits clocked in after a
  // reset that landed mid-frame are never counted toward a frame.
  logic        armed;
  logic [4:0]  bit_cnt;
  logic [15:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      bit_cnt <= 5'd0;
      shift   <= 16'd0;
    end else if (ncs_fall) begin
      armed   <= 1'b1;
      bit_cnt <= 5'd0;
    end else if (ncs_rise) begin
      armed   <= 1'b0;
    end else if (armed && !ncs_s2 && sclk_rise) begin
      shift <= {shift[14:0], copi_s2};
      if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  logic       commit;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  assign commit  = ncs_rise & armed & (bit_cnt == 5'd16) & shift[15];
  assign wr_addr = shift[14:8];
  assign wr_data = shift[7:0];

  logic [NUM_CH-1:0] out_en;
  logic [NUM_CH-1:0] pwm_en;
  logic [7:0]        duty     [NUM_CH];
  logic [7:0]        duty_act [NUM_CH];

  // Channel i lives in byte i/8, bit i%8; unmatched addresses simply hit no channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en <= '0;
      pwm_en <= '0;
      for (int i = 0; i < NUM_CH; i++) duty[i] <= 8'd0;
    end else if (commit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == 7'(i / 8))      out_en[i] <= wr_data[i % 8];
        if (wr_addr == 7'(8 + i / 8))  pwm_en[i] <= wr_data[i % 8];
        if (wr_addr == 7'(16 + i))     duty[i]   <= wr_data;
      end
    end
  end

  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic          tick;
  assign tick = (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= 8'd0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) cnt <= cnt + 8'd1;
    end
  end

  // Shadows reload only as cnt wraps, so a period is never torn by a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= 8'd0;
    end else if (tick && cnt == 8'hFF) begin
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty[i];
    end
  end

  logic [NUM_CH-1:0] pwm_bit;
  always_comb begin
    pwm_bit = '0;
    for (int i = 0; i < NUM_CH; i++)
      pwm_bit[i] = (duty_act[i] == 8'hFF) | (cnt < duty_act[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= '0;
    else        pwm_out <= out_en & (~pwm_en | pwm_bit);
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] rd_sh;
  logic       cipo_q;

  assign sclk_fall = ~sclk_s2 & sclk_d;
  // Address as it stands once the eighth bit is being shifted in.
  assign rd_addr   = {shift[5:0], copi_s2};

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == 7'(i / 8))     rd_data[i % 8] = out_en[i];
      if (rd_addr == 7'(8 + i / 8)) rd_data[i % 8] = pwm_en[i];
      if (rd_addr == 7'(16 + i))    rd_data        = duty[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sh  <= 8'd0;
      cipo_q <= 1'b0;
    end else if (ncs_s2) begin
      cipo_q <= 1'b0;
    end else if (armed && sclk_rise && bit_cnt == 5'd7) begin
      rd_sh <= shift[6] ? 8'h00 : rd_data;
    end else if (armed && sclk_fall && bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
      cipo_q <= rd_sh[7];
      rd_sh  <= {rd_sh[6:0], 1'b0};
    end
  end

  assign spi.CIPO = cipo_q;
`else
  assign spi.CIPO = 1'b0;
`endif

endmodule

// File: doc/spi_pwm_multichannel.md
# spi_pwm_multichannel

Parametrised SPI-configured PWM controller for the TinyTapeout user tile, generalising the fixed 16-output SPI/PWM pair. It presents NUM_CH outputs, each with its own output-enable, PWM-enable and 8-bit duty register. All registers are written over a synchronised SPI mode-0 slave. Duty updates are double-buffered so a PWM period is never torn.

## Interface
Parameters:
- NUM_CH, 16: number of PWM channels; legal range 1..64.
- CLK_DIV, 13: clk cycles per PWM counter tick, at least 1. PWM period = 256*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock, asynchronous to clk.
- nCS  in  1  SPI chip select, active low, asynchronous.
- COPI  in  1  SPI data in, asynchronous.
- CIPO  out  1  SPI data out; see Configuration.
- pwm_out  out  NUM_CH  registered channel outputs.

## Operation
- **Synchroniser:** SCLK, nCS and COPI each pass through 2 flops, then an edge-detect flop. Only the synchronised versions are used.
- **Frame format:** 16 bits, MSB first, COPI sampled on synchronised SCLK rising edges while nCS is low.
  - bit15: 1 = write, 0 = read.
  - bits14:8: address.
  - bits7:0: data.
- **Frame commit:** on the synchronised nCS rising edge, and only if exactly 16 bits were received.
  - Any other bit count discards the frame with no register change.
  - The bit counter saturates at 17.
  - The bit counter clears on the nCS falling edge.
- **Register map** (NB = ceil(NUM_CH/8)):
  - 0x00..0x07: out_en bytes, byte k = channels 8k..8k+7.
  - 0x08..0x0F: pwm_en bytes, same layout.
  - 0x10+i: duty_i for channel i < NUM_CH.
  - Writes to bytes at or above NB, to duty addresses at or above 0x10+NUM_CH, or to any other address are ignored.
  - Bits for channels at or above NUM_CH inside a valid byte are ignored and read as 0.
- **Prescaler:** counts 0..CLK_DIV-1. A tick is asserted when it wraps.
- **PWM counter:** cnt is 8 bits, increments on each tick, wraps 255 -> 0.
- **Duty shadowing:** each active duty_act_i loads from duty_i when cnt = 255 and tick is asserted, i.e. at the start of the next period.
- **Per-channel PWM bit:**
  - duty_act = 0xFF: constant 1.
  - Otherwise: 1 when cnt < duty_act; 0x00 gives constant 0.
- **Output:** pwm_out[i] is registered.
  - out_en[i] = 0: output 0.
  - out_en[i] = 1, pwm_en[i] = 0: output 1.
  - out_en[i] = 1, pwm_en[i] = 1: output is the PWM bit.
- **Reset values:**
  - All registers, shadows, counters and synchronisers: 0.
  - pwm_out = 0, CIPO = 0.
- **Reset mid-frame:** the frame is lost, registers return to 0, and a frame is recognised only after a fresh nCS falling edge.

## Timing
- SCLK high and low phases must each be at least 4 clk cycles. nCS must be high for at least 4 clk cycles between frames.
- Write latency: the register updates on clk edge 3 after the first edge that samples nCS high.
- Enable changes reach pwm_out one clk later (edge 4).
- Duty changes reach pwm_out at the first period boundary after the register update.
- A write that coincides with a shadow load in the same cycle is not seen by that load. The shadow keeps the old value for one more period.
- No simultaneous-write hazard exists, since only one frame commits per nCS edge.

## Configuration
- **SPI_READBACK_EN defined:**
  - For a read frame, once bit 8 (the final address bit) is received, the addressed register is latched into a shift register. Unmapped addresses read 0x00.
  - CIPO presents data MSB first, updating on each synchronised SCLK falling edge for bits 9..16.
  - CIPO returns to 0 on nCS high.
- **SPI_READBACK_EN undefined:**
  - CIPO is tied to 0.
  - Read frames are received and discarded with no side effects.

## Test plan
- **Enables without PWM:** after reset, write 0x00=0xFF and 0x01=0xFF, pwm_en = 0. Expect pwm_out = 16'hFFFF within 4 clk of nCS rising. Before the writes, pwm_out = 0.
- **50% duty:** write duty_0 = 0x80 and 0x08 = 0x01 with out_en[0] = 1. Expect channel 0 high for 128*13 clk and low for 128*13 clk per 3328-clk period, starting at the next period boundary.
- **Duty extremes:** duty_1 = 0xFF gives constant high. duty_1 = 0x00 gives constant low across 3 periods.
- **Mid-period duty change:** change duty_0 from 0x40 to 0xC0 while cnt = 0x20. The current period keeps its 64-tick high time; the next period has 192.
- **Bad frames and unmapped addresses:**
  - A 15-bit frame, then a 17-bit frame, each writing 0x00 = 0x0F: no register change.
  - A write to address 0x7F: no change to any output.
- **Reset and readback:**
  - Assert rst_n low mid-frame: all outputs 0 immediately, and a subsequent clean frame works.
  - With SPI_READBACK_EN, reading 0x10 after writing 0xA5 returns 0xA5 on CIPO.
